// File: rtl/text_console_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : text_console_ctrl_if
// Purpose  : Bundles the byte-stream input handshake (valid/ready), the video
//            RAM write port and the cursor/status outputs of the text console
//            write-side sequencer.
// Ports    : in_data/in_valid   byte source -> controller
//            in_ready           controller -> byte source
//            ram_din/ram_we/ram_waddr  controller -> video RAM write port
//            cur_col/cur_row    cursor position
//            busy               screen clear in progress
// Modports : master = byte source / observer side, slave = controller side
// Revision : 1.0 - initial release
// ============================================================================
interface text_console_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [6:0]        cur_col;
  logic [5:0]        cur_row;
  logic              busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, ram_din, ram_we, ram_waddr, cur_col, cur_row, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ram_din, ram_we, ram_waddr, cur_col, cur_row, busy
  );
endinterface
`default_nettype wire

// File: rtl/text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : text_console_ctrl
// Purpose  : Write-side sequencer for a COLS x ROWS text video RAM. Accepts a
//            byte stream, interprets printable characters and CR/LF/BS/FF
//            control codes, tracks the cursor and drives the RAM write port.
//            FF blanks the whole RAM, one cell per cycle.
// Ports    : clk   system clock (also RAM write clock)
//            rst   synchronous active-high reset
//            bus   text_console_ctrl_if.slave (byte input handshake, RAM
//                  write port, cursor and busy outputs)
// Config   : CLEAR_ON_RESET_EN - when defined, leaving reset starts a full
//            screen clear before the first byte is accepted; otherwise the
//            controller comes out of reset idle and the RAM is left untouched.
// Revision : 1.0 - initial release
// ============================================================================
module text_console_ctrl #(
  parameter int         COLS     = 80,
  parameter int         ROWS     = 60,
  parameter int         RAM_SIZE = COLS * ROWS,
  parameter int         ADDR_W   = $clog2(RAM_SIZE),
  parameter logic [7:0] BLANK    = 8'h20
) (
  input  wire logic          clk,
  input  wire logic          rst,
  text_console_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

`ifdef CLEAR_ON_RESET_EN
  localparam state_t c_reset_state = ST_CLEAR;
`else
  localparam state_t c_reset_state = ST_IDLE;
`endif

  localparam logic [6:0]        c_col_last  = 7'(COLS - 1);
  localparam logic [5:0]        c_row_last  = 6'(ROWS - 1);
  localparam logic [ADDR_W-1:0] c_addr_last = ADDR_W'(RAM_SIZE - 1);
  localparam logic [ADDR_W:0]   c_cols_ext  = (ADDR_W+1)'(COLS);
  localparam logic [ADDR_W:0]   c_size_ext  = (ADDR_W+1)'(RAM_SIZE);

  localparam logic [7:0] c_cr = 8'h0D;
  localparam logic [7:0] c_lf = 8'h0A;
  localparam logic [7:0] c_bs = 8'h08;
  localparam logic [7:0] c_ff = 8'h0C;

  state_t            r_state, w_state_nxt;
  logic [6:0]        r_col,   w_col_nxt;
  logic [5:0]        r_row,   w_row_nxt;
  // Linear cell address of the cursor (row*COLS + col), maintained
  // incrementally so no multiplier is needed.
  logic [ADDR_W-1:0] r_lin,   w_lin_nxt;
  logic [ADDR_W-1:0] r_clr,   w_clr_nxt;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic [7:0]        r_din,   w_din_nxt;
  logic              r_we,    w_we_nxt;

  logic              w_ready;
  logic              w_accept;
  logic              w_printable;
  logic [ADDR_W:0]   w_lf_sum;
  logic [ADDR_W-1:0] w_lf_lin;

  assign w_ready     = (r_state == ST_IDLE) & ~rst;
  assign w_accept    = bus.in_valid & w_ready;
  assign w_printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);

  // LF moves one full row down; the address wraps modulo RAM_SIZE so the
  // bottom row feeds back to the top row at the same column.
  assign w_lf_sum = {1'b0, r_lin} + c_cols_ext;
  assign w_lf_lin = (w_lf_sum >= c_size_ext) ? ADDR_W'(w_lf_sum - c_size_ext)
                                             : ADDR_W'(w_lf_sum);

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_reset_state;
      r_col   <= '0;
      r_row   <= '0;
      r_lin   <= '0;
      r_clr   <= '0;
      r_waddr <= '0;
      r_din   <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_lin   <= w_lin_nxt;
      r_clr   <= w_clr_nxt;
      r_waddr <= w_waddr_nxt;
      r_din   <= w_din_nxt;
      r_we    <= w_we_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_lin_nxt   = r_lin;
    w_clr_nxt   = r_clr;
    w_waddr_nxt = r_waddr;   // address and data hold between writes
    w_din_nxt   = r_din;
    w_we_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_clr_nxt = '0;
        if (w_accept) begin
          if (w_printable) begin
            w_we_nxt    = 1'b1;
            w_din_nxt   = bus.in_data;
            w_waddr_nxt = r_lin;
            if (r_col == c_col_last) begin
              w_col_nxt = '0;
              if (r_row == c_row_last) begin
                // Bottom-right cell: wrap to the top-left, no scrolling.
                w_row_nxt = '0;
                w_lin_nxt = '0;
              end else begin
                w_row_nxt = r_row + 6'd1;
                w_lin_nxt = r_lin + ADDR_W'(1);
              end
            end else begin
              w_col_nxt = r_col + 7'd1;
              w_lin_nxt = r_lin + ADDR_W'(1);
            end
          end else begin
            case (bus.in_data)
              c_cr: begin
                w_col_nxt = '0;
                w_lin_nxt = r_lin - ADDR_W'(r_col);
              end
              c_lf: begin
                w_row_nxt = (r_row == c_row_last) ? 6'd0 : r_row + 6'd1;
                w_lin_nxt = w_lf_lin;
              end
              c_bs: begin
                // Backspace only moves the cursor; the cell is not erased.
                if (r_col != 7'd0) begin
                  w_col_nxt = r_col - 7'd1;
                  w_lin_nxt = r_lin - ADDR_W'(1);
                end
              end
              c_ff: begin
                w_state_nxt = ST_CLEAR;
              end
              default: ;  // unsupported bytes are consumed and dropped
            endcase
          end
        end
      end

      ST_CLEAR: begin
        w_we_nxt    = 1'b1;
        w_din_nxt   = BLANK;
        w_waddr_nxt = r_clr;
        if (r_clr == c_addr_last) begin
          w_state_nxt = ST_IDLE;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
          w_lin_nxt   = '0;
          w_clr_nxt   = '0;
        end else begin
          w_clr_nxt = r_clr + ADDR_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = w_ready;
  assign bus.ram_din   = r_din;
  assign bus.ram_we    = r_we;
  assign bus.ram_waddr = r_waddr;
  assign bus.cur_col   = r_col;
  assign bus.cur_row   = r_row;
  // Gated by rst so status reads idle while reset is held, whatever the
  // reset state of the sequencer.
  assign bus.busy      = (r_state == ST_CLEAR) & ~rst;

endmodule
`default_nettype wire
